// File: rtl/fmul_pkg.sv
// fmul_pkg: shared constants and types for the binary32 multiplier add/normalise stage
package fmul_pkg;
  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;
  localparam logic [7:0] EXP_MAX = 8'hff;
  localparam logic [30:0] INF_MAG = {EXP_MAX, 23'h0};
  localparam logic [30:0] MAX_MAG = {8'hfe, 23'h7fffff};
  localparam int FLAG_NV = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;
  typedef struct packed {
    logic [1:0]  rm;
    logic        sign;
    logic [9:0]  exp10;
    logic        is_nan;
    logic        is_inf;
    logic [22:0] frac;
    logic [47:0] prod;
  } p_t;
endpackage

// File: rtl/fmul_lzc48.sv
// fmul_lzc48: combinational 48-bit leading-zero count (48 for an all-zero input)
module fmul_lzc48 (
  input  logic [47:0] val_i,
  output logic [5:0]  cnt_o
);
  always_comb begin
    cnt_o = 6'd48;
    for (int i = 0; i < 48; i++)
      if (val_i[i]) cnt_o = 6'(47 - i);
  end
endmodule

// File: rtl/fmul_add_norm_stage.sv
// fmul_add_norm_stage: product resolve, normalise, round and pack for binary32 multiply.
// Define FMUL_FLAGS_EN to add the registered s_flags {NV,OF,UF,NX} output.
module fmul_add_norm_stage
  import fmul_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  a_rm,
  input  logic        a_sign,
  input  logic [9:0]  a_exp10,
  input  logic        a_is_nan,
  input  logic        a_is_inf,
  input  logic [22:0] a_inf_nan_frac,
  input  logic [39:0] a_sum,
  input  logic [39:0] a_carry,
  input  logic [7:0]  a_z8,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] s_result
`ifdef FMUL_FLAGS_EN
  ,
  output logic [3:0]  s_flags
`endif
);
  p_t p_q, p_d;
  logic p_v_q, p_v_d, r_v_q, r_v_d, adv;
  logic [31:0] res_q, res_d;
  logic [5:0] lz;
  logic signed [11:0] e0, e1, rsh_s;
  logic [11:0] lim, lzm1, sh, rsh, efield;
  logic [47:0] m, m2;
  logic [23:0] sig;
  logic [34:0] rnd;
  logic s0, g, st, inc, ovf, to_inf;
  fmul_lzc48 u_lzc (.val_i(p_q.prod), .cnt_o(lz));
  always_comb begin
    adv = p_v_q & (!r_v_q | out_ready);
    in_ready = !p_v_q | !r_v_q | out_ready;
    p_v_d = in_ready ? in_valid : p_v_q;
    r_v_d = adv | (r_v_q & !out_ready);
    p_d = '{a_rm, a_sign, a_exp10, a_is_nan, a_is_inf, a_inf_nan_frac, {a_sum + a_carry, a_z8}};
  end
  // Normalise so the hidden bit sits at m[46]; never let the exponent drop below 1 here.
  always_comb begin
    e0 = {{2{p_q.exp10[9]}}, p_q.exp10};
    lim = (e0 > 12'sd1) ? 12'(e0 - 12'sd1) : 12'd0;
    lzm1 = {6'd0, lz} - 12'd1;
    sh = p_q.prod[47] ? 12'd0 : (lzm1 < lim ? lzm1 : lim);
    m = p_q.prod[47] ? p_q.prod >> 1 : p_q.prod << sh;
    s0 = p_q.prod[47] & p_q.prod[0];
    e1 = p_q.prod[47] ? e0 + 12'sd1 : e0 - $signed(sh);
    rsh_s = 12'sd1 - e1;
    rsh = (e1 > 12'sd0) ? 12'd0 : (rsh_s > 12'sd26 ? 12'd26 : 12'(rsh_s));
    m2 = m >> rsh;
    sig = m2[46:23];
    g = m2[22];
    st = s0 | ((m2 << rsh) != m) | (|m2[21:0]);
    efield = sig[23] ? 12'(e1) : 12'd0;
    inc = (p_q.rm == RM_RNE) ? g & (st | sig[0]) :
          (p_q.rm == RM_RUP) ? !p_q.sign & (g | st) :
          (p_q.rm == RM_RDN) ? p_q.sign & (g | st) : 1'b0;
    rnd = {efield, sig[22:0]} + {34'd0, inc};
    ovf = rnd[34:23] >= 12'd255;
    to_inf = (p_q.rm == RM_RNE) | (p_q.rm == RM_RUP & !p_q.sign) | (p_q.rm == RM_RDN & p_q.sign);
    res_d = p_q.is_nan ? {p_q.sign, EXP_MAX, p_q.frac} :
            p_q.is_inf ? {p_q.sign, INF_MAG} :
            ovf        ? {p_q.sign, to_inf ? INF_MAG : MAX_MAG} :
                         {p_q.sign, rnd[30:0]};
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      p_v_q <= 1'b0;
      r_v_q <= 1'b0;
      p_q <= '0;
      res_q <= '0;
    end else begin
      p_v_q <= p_v_d;
      r_v_q <= r_v_d;
      if (in_valid & in_ready) p_q <= p_d;
      if (adv) res_q <= res_d;
    end
  end
  assign out_valid = r_v_q;
  assign s_result = res_q;
`ifdef FMUL_FLAGS_EN
  logic [3:0] flg_q, flg_d;
  logic nx;
  always_comb begin
    nx = g | st;
    flg_d = '0;
    flg_d[FLAG_NV] = p_q.is_nan;
    flg_d[FLAG_OF] = !p_q.is_nan & !p_q.is_inf & ovf;
    flg_d[FLAG_UF] = !p_q.is_nan & !p_q.is_inf & !ovf & (efield == 12'd0) & nx;
    flg_d[FLAG_NX] = !p_q.is_nan & !p_q.is_inf & (ovf | nx);
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) flg_q <= '0;
    else if (adv) flg_q <= flg_d;
  end
  assign s_flags = flg_q;
`endif
endmodule

// File: tb/tb_fmul_add_norm_stage.sv
// tb_fmul_add_norm_stage: directed self-checking bench for fmul_add_norm_stage
module tb_fmul_add_norm_stage;
  logic clk = 1'b0;
  logic clr, in_valid, in_ready, a_sign, a_is_nan, a_is_inf, out_valid, out_ready;
  logic [1:0] a_rm;
  logic [9:0] a_exp10;
  logic [22:0] a_inf_nan_frac;
  logic [39:0] a_sum, a_carry;
  logic [7:0] a_z8;
  logic [31:0] s_result;
  int total = 0;
  int bad = 0;
`ifdef FMUL_FLAGS_EN
  logic [3:0] s_flags;
`endif
  always #5 clk = ~clk;
  fmul_add_norm_stage dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .a_rm(a_rm), .a_sign(a_sign), .a_exp10(a_exp10), .a_is_nan(a_is_nan), .a_is_inf(a_is_inf),
    .a_inf_nan_frac(a_inf_nan_frac), .a_sum(a_sum), .a_carry(a_carry), .a_z8(a_z8),
    .out_valid(out_valid), .out_ready(out_ready), .s_result(s_result)
`ifdef FMUL_FLAGS_EN
    , .s_flags(s_flags)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [1:0] rm, input logic sg, input logic [9:0] ex,
                       input logic nan, input logic inf, input logic [22:0] fr,
                       input logic [39:0] sm, input logic [39:0] cy, input logic [7:0] z);
    a_rm = rm; a_sign = sg; a_exp10 = ex; a_is_nan = nan; a_is_inf = inf;
    a_inf_nan_frac = fr; a_sum = sm; a_carry = cy; a_z8 = z;
  endtask
  task automatic run_one(input string tag, input logic [1:0] rm, input logic sg, input logic [9:0] ex,
                         input logic nan, input logic inf, input logic [22:0] fr,
                         input logic [39:0] sm, input logic [39:0] cy, input logic [7:0] z,
                         input logic [31:0] er, input logic [3:0] ef);
    @(negedge clk);
    drive(rm, sg, ex, nan, inf, fr, sm, cy, z);
    in_valid = 1'b1;
    chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".result"}, s_result, er);
`ifdef FMUL_FLAGS_EN
    chk({tag, ".flags"}, {28'd0, s_flags}, {28'd0, ef});
`endif
  endtask
  initial begin
    clr = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(2'b00, 1'b0, 10'd0, 1'b0, 1'b0, 23'd0, 40'd0, 40'd0, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.result", s_result, 32'd0);
`ifdef FMUL_FLAGS_EN
    chk("rst.flags", {28'd0, s_flags}, 32'd0);
`endif
    @(negedge clk); clr = 1'b0;
    @(negedge clk);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    run_one("three",     2'b00, 1'b0, 10'd128, 1'b0, 1'b0, 23'd0, 40'h6000000000, 40'd0, 8'h00, 32'h40400000, 4'b0000);
    run_one("carry_add", 2'b00, 1'b0, 10'd127, 1'b0, 1'b0, 23'd0, 40'h2000000000, 40'h2000000000, 8'h00, 32'h3f800000, 4'b0000);
    run_one("ovf_rne",   2'b00, 1'b0, 10'd300, 1'b0, 1'b0, 23'd0, 40'h8000000000, 40'd0, 8'h00, 32'h7f800000, 4'b0101);
    run_one("ovf_rtz",   2'b01, 1'b0, 10'd300, 1'b0, 1'b0, 23'd0, 40'h8000000000, 40'd0, 8'h00, 32'h7f7fffff, 4'b0101);
    run_one("nan",       2'b00, 1'b0, 10'd5,   1'b1, 1'b0, 23'h400000, 40'h4000000000, 40'd0, 8'h00, 32'h7fc00000, 4'b1000);
    run_one("inf_neg",   2'b00, 1'b1, 10'd5,   1'b0, 1'b1, 23'h400000, 40'h4000000000, 40'd0, 8'h00, 32'hff800000, 4'b0000);
    run_one("tiny_rne",  2'b00, 1'b0, 10'h3e2, 1'b0, 1'b0, 23'd0, 40'h4000000000, 40'd0, 8'h00, 32'h00000000, 4'b0011);
    run_one("tiny_rup",  2'b10, 1'b0, 10'h3e2, 1'b0, 1'b0, 23'd0, 40'h4000000000, 40'd0, 8'h00, 32'h00000001, 4'b0011);
    run_one("zero_neg",  2'b00, 1'b1, 10'd100, 1'b0, 1'b0, 23'd0, 40'd0, 40'd0, 8'h00, 32'h80000000, 4'b0000);
    run_one("rne_tie_up",2'b00, 1'b0, 10'd127, 1'b0, 1'b0, 23'd0, 40'h400000C000, 40'd0, 8'h00, 32'h3f800002, 4'b0001);
    run_one("rtz_trunc", 2'b01, 1'b0, 10'd127, 1'b0, 1'b0, 23'd0, 40'h400000C000, 40'd0, 8'h00, 32'h3f800001, 4'b0001);
    run_one("z8_sticky", 2'b00, 1'b0, 10'd127, 1'b0, 1'b0, 23'd0, 40'h4000004000, 40'd0, 8'h01, 32'h3f800001, 4'b0001);
    run_one("lshift",    2'b00, 1'b0, 10'd127, 1'b0, 1'b0, 23'd0, 40'h1000000000, 40'd0, 8'h00, 32'h3e800000, 4'b0000);
    run_one("lshift_lim",2'b00, 1'b0, 10'd2,   1'b0, 1'b0, 23'd0, 40'h1000000000, 40'd0, 8'h00, 32'h00400000, 4'b0000);
    // Backpressure: four back-to-back operands with the consumer stalled.
    @(negedge clk);
    out_ready = 1'b0;
    drive(2'b00, 1'b0, 10'd128, 1'b0, 1'b0, 23'd0, 40'h6000000000, 40'd0, 8'h00);
    in_valid = 1'b1;
    @(negedge clk);
    chk("bp.ready1", {31'd0, in_ready}, 32'd1);
    drive(2'b00, 1'b0, 10'd127, 1'b0, 1'b0, 23'd0, 40'h4000000000, 40'd0, 8'h00);
    @(negedge clk);
    chk("bp.ready_full", {31'd0, in_ready}, 32'd0);
    chk("bp.hold_valid", {31'd0, out_valid}, 32'd1);
    chk("bp.hold_a", s_result, 32'h40400000);
    drive(2'b00, 1'b0, 10'd128, 1'b0, 1'b0, 23'd0, 40'h4000000000, 40'd0, 8'h00);
    @(negedge clk);
    chk("bp.ready_held", {31'd0, in_ready}, 32'd0);
    chk("bp.stable_a", s_result, 32'h40400000);
    @(negedge clk);
    chk("bp.stable_a2", s_result, 32'h40400000);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp.out_b", s_result, 32'h3f800000);
    drive(2'b00, 1'b0, 10'd127, 1'b0, 1'b0, 23'd0, 40'h6000000000, 40'd0, 8'h00);
    @(negedge clk);
    chk("bp.out_c", s_result, 32'h40000000);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp.out_d", s_result, 32'h3fc00000);
    chk("bp.out_d_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    chk("bp.drained", {31'd0, out_valid}, 32'd0);
    // Asynchronous clear with both slices occupied.
    out_ready = 1'b0;
    drive(2'b00, 1'b0, 10'd128, 1'b0, 1'b0, 23'd0, 40'h6000000000, 40'd0, 8'h00);
    in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("clr.full", {31'd0, in_ready}, 32'd0);
    #2 clr = 1'b1;
    #1;
    chk("clr.out_valid", {31'd0, out_valid}, 32'd0);
    chk("clr.result", s_result, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    out_ready = 1'b1;
    run_one("after_clr", 2'b00, 1'b0, 10'd127, 1'b0, 1'b0, 23'd0, 40'h4000000000, 40'd0, 8'h00, 32'h3f800000, 4'b0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
